apb_master_param: RTL
=====================

Name: apb_master_param

Overview:
Parametrised APB (AMBA 3/4) master. It accepts single read/write commands on a valid/ready request port and runs one SETUP+ACCESS transfer to one of NUM_SLAVES slaves, chosen by decoding the upper address bits. It returns read data and an error/timeout status as a one-cycle response pulse. It sits between a local command source (CPU/DMA/test sequencer) and the peripheral APB fabric, and replaces the fixed 8-bit single-slave master.

Parameters:
- ADDR_W, 8, paddr/cmd_addr width.
- DATA_W, 8, data width; multiple of 8.
- NUM_SLAVES, 3, number of psel lines, range 1..16.
- TIMEOUT, 16, maximum ACCESS cycles waiting for pready; 0 disables the timeout.
- Derived localparams: STRB_W = DATA_W/8; SEL_W = clog2(NUM_SLAVES), forced to 0 when NUM_SLAVES = 1.

Ports:
- clk, in, 1, clock; all logic on the rising edge.
- preset, in, 1, reset; asynchronous, active-low.
- cmd_valid, in, 1, command request.
- cmd_ready, out, 1, master can accept a command; high only in IDLE.
- cmd_write, in, 1, 1 = write, 0 = read.
- cmd_addr, in, ADDR_W, target address.
- cmd_wdata, in, DATA_W, write data.
- cmd_strb, in, STRB_W, write byte strobes.
- rsp_valid, out, 1, one-cycle completion pulse.
- rsp_rdata, out, DATA_W, read data; 0 for writes and for errors.
- rsp_err, out, 1, pslverr, decode error, or timeout.
- rsp_timeout, out, 1, completion was a timeout.
- psel, out, NUM_SLAVES, one-hot slave select.
- penable, out, 1, APB enable.
- pwrite, out, 1, APB direction.
- paddr, out, ADDR_W, APB address.
- pwdata, out, DATA_W, APB write data.
- pstrb, out, STRB_W, APB strobes; 0 on reads.
- pready, in, NUM_SLAVES, per-slave ready.
- prdata, in, NUM_SLAVES*DATA_W, per-slave read data; slave i occupies [i*DATA_W +: DATA_W].
- pslverr, in, NUM_SLAVES, per-slave error.

Behaviour:
- Reset (preset low, asynchronous):
  - state = IDLE.
  - psel, penable, pwrite, paddr, pwdata, pstrb = 0.
  - rsp_valid, rsp_rdata, rsp_err, rsp_timeout = 0; timeout counter = 0.
  - cmd_ready is decoded from state, so it is 1 in reset.
- All APB and rsp outputs are registered. No combinational path from pready to any output.
- Slave decode: idx = cmd_addr[ADDR_W-1 -: SEL_W]. idx >= NUM_SLAVES is a decode error. When NUM_SLAVES = 1, every address decodes to slave 0.
- IDLE:
  - cmd_ready = 1; psel = 0; penable = 0.
  - Accept when cmd_valid is high. Latch write, addr, wdata, strb and idx.
  - Valid idx: go to SETUP. Decode error: go to DERR.
- SETUP (exactly one cycle):
  - psel[idx] = 1, penable = 0, paddr/pwrite driven.
  - pwdata/pstrb = latched values on writes; pwdata = 0 and pstrb = 0 on reads.
  - Always go to ACCESS.
- ACCESS:
  - penable = 1. psel, paddr, pwrite, pwdata and pstrb stay stable for the whole state.
  - Counter increments each cycle that pready[idx] is low.
  - pready[idx] = 1: capture prdata slice (reads only) and pslverr[idx]. Next cycle: rsp_valid = 1, rsp_err = pslverr, psel = 0, penable = 0, state = IDLE.
  - Counter reaches TIMEOUT (TIMEOUT > 0) with pready still low: abort. Next cycle: rsp_valid = 1, rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0, psel and penable drop, state = IDLE.
  - pready and the timeout in the same cycle: pready wins.
- DERR (one cycle): no psel asserted. rsp_valid = 1 and rsp_err = 1 on the next cycle, then IDLE.
- Latency:
  - Accept at edge N; SETUP in cycle N+1; ACCESS from N+2.
  - Zero-wait transfer: rsp_valid in cycle N+3, which is also when cmd_ready returns to 1.
  - Back-to-back commands give one transfer per 3 cycles minimum.
  - Decode error: rsp_valid at N+2.
- The response is a single-cycle pulse with no backpressure. The consumer must sample it.
- pready, prdata and pslverr from unselected slaves are ignored. pready outside ACCESS is ignored.
- Reset mid-transfer: the bus drops immediately (psel and penable go to 0), no response is issued, and the command is lost.

Decomposition:
- Package apb_pkg:
  - state enum {IDLE, SETUP, ACCESS, DERR}.
  - clog2 helper function.
  - response-status localparams.
- Sub-module apb_slave_decode (combinational): addr -> one-hot sel plus decode_ok.
- The FSM and timeout counter stay in apb_master_param.

Test Plan:
1. Write, zero wait. cmd addr=0x05, wdata=0xA5, strb=1, pready[0]=1 in ACCESS. Expect psel=3'b001; SETUP then ACCESS on consecutive cycles; pwdata=0xA5; rsp_valid 3 cycles after accept, rsp_err=0.
2. Read with 2 wait states. Addr 0x41 (slave 1); pready[1] low for 2 ACCESS cycles, then high with prdata[15:8]=0x3C. Expect psel=3'b010; penable held 3 cycles; pstrb=0; rsp_rdata=0x3C at accept+5.
3. Slave error. Write to 0x80 (slave 2) with pslverr[2]=1 and pready=1. Expect rsp_err=1 and rsp_timeout=0.
4. Decode error. Addr 0xC0 (idx=3, NUM_SLAVES=3). Expect psel stays 0; rsp_valid with rsp_err=1 at accept+2.
5. Timeout. Slave never readies. Expect abort after 16 ACCESS cycles; rsp_err=1, rsp_timeout=1, rsp_rdata=0; psel low the cycle after.
6. Reset mid-ACCESS. Assert preset low during ACCESS. Expect psel, penable and rsp_valid go to 0 asynchronously and no response. After release, a new read completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and helpers for the parametrised APB master.
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      DERR
   } apb_state_e;

   localparam logic [1:0] RSP_OKAY    = 2'd0;
   localparam logic [1:0] RSP_SLVERR  = 2'd1;
   localparam logic [1:0] RSP_DECERR  = 2'd2;
   localparam logic [1:0] RSP_TIMEOUT = 2'd3;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/apb_slave_decode.sv
// Maps the upper address bits onto a one-hot slave select.
module apb_slave_decode
   import apb_pkg::*;
#(
   parameter int ADDR_W     = 8,
   parameter int NUM_SLAVES = 3
) (
   input  logic [ADDR_W-1:0]     addr,
   output logic [NUM_SLAVES-1:0] sel,
   output logic                  decode_ok
);

   localparam int SEL_W = (NUM_SLAVES > 1) ? clog2(NUM_SLAVES) : 0;

   // Only the top SEL_W bits select a slave; the rest belong to the slave.
   logic unused_addr;
   assign unused_addr = ^addr;

   generate
      if (NUM_SLAVES == 1) begin : g_single
         assign sel       = 1'b1;
         assign decode_ok = 1'b1;
      end else begin : g_multi
         logic [SEL_W-1:0] idx;
         assign idx       = addr[ADDR_W-1 -: SEL_W];
         assign decode_ok = (int'(idx) < NUM_SLAVES);
         for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_sel
            assign sel[gi] = (idx == SEL_W'(gi));
         end
      end
   endgenerate

endmodule

// File: rtl/apb_master_param.sv
// Single-command APB master: SETUP+ACCESS transfer with decode error,
// pslverr and timeout reporting on a one-cycle response pulse.
module apb_master_param
   import apb_pkg::*;
#(
   parameter int  ADDR_W     = 8,
   parameter int  DATA_W     = 8,
   parameter int  NUM_SLAVES = 3,
   parameter int  TIMEOUT    = 16,
   localparam int STRB_W     = DATA_W / 8
) (
   input  logic                         clk,
   input  logic                         preset,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic                         cmd_write,
   input  logic [ADDR_W-1:0]            cmd_addr,
   input  logic [DATA_W-1:0]            cmd_wdata,
   input  logic [STRB_W-1:0]            cmd_strb,
   output logic                         rsp_valid,
   output logic [DATA_W-1:0]            rsp_rdata,
   output logic                         rsp_err,
   output logic                         rsp_timeout,
   output logic [NUM_SLAVES-1:0]        psel,
   output logic                         penable,
   output logic                         pwrite,
   output logic [ADDR_W-1:0]            paddr,
   output logic [DATA_W-1:0]            pwdata,
   output logic [STRB_W-1:0]            pstrb,
   input  logic [NUM_SLAVES-1:0]        pready,
   input  logic [NUM_SLAVES*DATA_W-1:0] prdata,
   input  logic [NUM_SLAVES-1:0]        pslverr
);

   localparam int CNT_W   = (TIMEOUT > 0) ? clog2(TIMEOUT + 1) : 1;
   localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

   apb_state_e              state_reg, state_next;
   logic [NUM_SLAVES-1:0]   psel_reg, psel_next;
   logic                    penable_reg, penable_next;
   logic                    pwrite_reg, pwrite_next;
   logic [ADDR_W-1:0]       paddr_reg, paddr_next;
   logic [DATA_W-1:0]       pwdata_reg, pwdata_next;
   logic [STRB_W-1:0]       pstrb_reg, pstrb_next;
   logic                    rsp_valid_reg, rsp_valid_next;
   logic [DATA_W-1:0]       rsp_rdata_reg, rsp_rdata_next;
   logic                    rsp_err_reg, rsp_err_next;
   logic                    rsp_timeout_reg, rsp_timeout_next;
   logic [CNT_W-1:0]        cnt_reg, cnt_next;

   logic [NUM_SLAVES-1:0]   dec_sel;
   logic                    decode_ok;
   logic                    rdy_sel;
   logic                    err_sel;
   logic [DATA_W-1:0]       prdata_sel;
   logic                    done;
   logic [1:0]              status;

   apb_slave_decode #(
      .ADDR_W     (ADDR_W),
      .NUM_SLAVES (NUM_SLAVES)
   ) u_decode (
      .addr      (cmd_addr),
      .sel       (dec_sel),
      .decode_ok (decode_ok)
   );

   // The registered one-hot psel doubles as the return-path mux select.
   logic [DATA_W-1:0] prdata_masked [NUM_SLAVES];
   generate
      for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_rmux
         assign prdata_masked[gi] = psel_reg[gi] ? prdata[gi*DATA_W +: DATA_W] : '0;
      end
   endgenerate

   always_comb begin
      prdata_sel = '0;
      for (int i = 0; i < NUM_SLAVES; i++) prdata_sel = prdata_sel | prdata_masked[i];
   end

   assign rdy_sel = |(pready & psel_reg);
   assign err_sel = |(pslverr & psel_reg);

   always_comb begin
      state_next       = state_reg;
      psel_next        = psel_reg;
      penable_next     = penable_reg;
      pwrite_next      = pwrite_reg;
      paddr_next       = paddr_reg;
      pwdata_next      = pwdata_reg;
      pstrb_next       = pstrb_reg;
      cnt_next         = cnt_reg;
      rsp_valid_next   = 1'b0;
      rsp_rdata_next   = '0;
      rsp_err_next     = 1'b0;
      rsp_timeout_next = 1'b0;
      done             = 1'b0;
      status           = RSP_OKAY;

      case (state_reg)
         IDLE: begin
            if (cmd_valid) begin
               pwrite_next = cmd_write;
               paddr_next  = cmd_addr;
               pwdata_next = cmd_write ? cmd_wdata : '0;
               pstrb_next  = cmd_write ? cmd_strb : '0;
               cnt_next    = '0;
               if (decode_ok) begin
                  psel_next  = dec_sel;
                  state_next = SETUP;
               end else begin
                  state_next = DERR;
               end
            end
         end
         SETUP: begin
            penable_next = 1'b1;
            state_next   = ACCESS;
         end
         ACCESS: begin
            // pready is checked first so it wins over a coincident timeout.
            if (rdy_sel) begin
               done   = 1'b1;
               status = err_sel ? RSP_SLVERR : RSP_OKAY;
               if (!pwrite_reg && !err_sel) rsp_rdata_next = prdata_sel;
            end else if (TIMEOUT > 0 && cnt_reg == CNT_W'(TO_LAST)) begin
               done   = 1'b1;
               status = RSP_TIMEOUT;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         DERR: begin
            done   = 1'b1;
            status = RSP_DECERR;
         end
         default: state_next = IDLE;
      endcase

      if (done) begin
         state_next       = IDLE;
         psel_next        = '0;
         penable_next     = 1'b0;
         cnt_next         = '0;
         rsp_valid_next   = 1'b1;
         rsp_err_next     = (status != RSP_OKAY);
         rsp_timeout_next = (status == RSP_TIMEOUT);
      end
   end

   always_ff @(posedge clk or negedge preset) begin
      if (!preset) begin
         state_reg       <= IDLE;
         psel_reg        <= '0;
         penable_reg     <= 1'b0;
         pwrite_reg      <= 1'b0;
         paddr_reg       <= '0;
         pwdata_reg      <= '0;
         pstrb_reg       <= '0;
         cnt_reg         <= '0;
         rsp_valid_reg   <= 1'b0;
         rsp_rdata_reg   <= '0;
         rsp_err_reg     <= 1'b0;
         rsp_timeout_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         psel_reg        <= psel_next;
         penable_reg     <= penable_next;
         pwrite_reg      <= pwrite_next;
         paddr_reg       <= paddr_next;
         pwdata_reg      <= pwdata_next;
         pstrb_reg       <= pstrb_next;
         cnt_reg         <= cnt_next;
         rsp_valid_reg   <= rsp_valid_next;
         rsp_rdata_reg   <= rsp_rdata_next;
         rsp_err_reg     <= rsp_err_next;
         rsp_timeout_reg <= rsp_timeout_next;
      end
   end

   assign cmd_ready   = (state_reg == IDLE);
   assign psel        = psel_reg;
   assign penable     = penable_reg;
   assign pwrite      = pwrite_reg;
   assign paddr       = paddr_reg;
   assign pwdata      = pwdata_reg;
   assign pstrb       = pstrb_reg;
   assign rsp_valid   = rsp_valid_reg;
   assign rsp_rdata   = rsp_rdata_reg;
   assign rsp_err     = rsp_err_reg;
   assign rsp_timeout = rsp_timeout_reg;

endmodule
